// File: rtl/pulse_param_sched_pkg.sv
// Shared definitions for the pulse-core parameter scheduler: control codes,
// reset timing defaults, FSM encodings and the committed-configuration layout.
package pulse_param_sched_pkg;

  localparam logic [31:0] ATT_DELAY       = 32'd20000;
  localparam logic [23:0] TIMEOUT_DEFAULT = 24'd120000;

  localparam logic [31:0] ST_PERIOD = 32'd200000;
  localparam logic [31:0] ST_P1W    = 32'd30;
  localparam logic [31:0] ST_P2W    = 32'd30;
  localparam logic [31:0] ST_DELAY  = 32'd200;

  typedef enum logic [7:0] {
    CONT_SET_DELAY   = 8'd0,
    CONT_SET_PERIOD  = 8'd1,
    CONT_SET_PUMP    = 8'd2,
    CONT_SET_PROBE   = 8'd3,
    CONT_TOGGLE_PUMP = 8'd4,
    CONT_SET_ATT     = 8'd5,
    CONT_READ_TEST   = 8'd6
  } cont_e;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_DATA = 2'd1,
    RX_CTRL = 2'd2,
    RX_EXEC = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_WAIT_HI = 2'd1,
    TX_WAIT_LO = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] p1width;
    logic [31:0] p2width;
    logic [31:0] delay;
    logic        pump;
    logic        double;
    logic        pp_on;
    logic [6:0]  pp_probe;
    logic [6:0]  pp_pump;
    logic [6:0]  post_att;
  } cfg_t;

  typedef struct packed {
    logic [31:0] p2start;
    logic [31:0] sync_up;
    logic [31:0] att_down;
  } edges_t;

  localparam cfg_t CFG_RESET = '{
    period:   ST_PERIOD,
    p1width:  ST_P1W,
    p2width:  ST_P2W,
    delay:    ST_DELAY,
    pump:     1'b1,
    double:   1'b0,
    pp_on:    1'b1,
    pp_probe: 7'h7F,
    pp_pump:  7'h00,
    post_att: 7'h00
  };

  // All edge sums wrap at 32 bits; the core tolerates wrap, saturation would hide bad settings.
  function automatic edges_t derive_edges(input cfg_t c);
    edges_t e;
    e.p2start  = c.p1width + c.delay;
    e.sync_up  = e.p2start + c.p2width;
    e.att_down = e.sync_up + ATT_DELAY;
    return e;
  endfunction

  localparam edges_t EDGES_RESET = derive_edges(CFG_RESET);

endpackage

// File: rtl/pulse_param_sched_bank.sv
// Shadow/active parameter register pairs with atomic commit on period_end
// and registered derived edges (valid one cycle after the commit).
module pulse_param_sched_bank
  import pulse_param_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_code,
  input  logic [31:0] wr_data,
  input  logic        period_end,
  output cfg_t        active,
  output edges_t      edges,
  output logic        cfg_pending
);

  cfg_t shadow;
  cfg_t shadow_next;
  logic wr_hit;

  always_comb begin
    shadow_next = shadow;
    wr_hit      = 1'b0;
    if (wr_en) begin
      case (wr_code)
        CONT_SET_DELAY: begin
          shadow_next.delay = wr_data;
          wr_hit = 1'b1;
        end
        CONT_SET_PERIOD: begin
          shadow_next.period = wr_data;
          wr_hit = 1'b1;
        end
        CONT_SET_PUMP: begin
          shadow_next.p1width = wr_data;
          wr_hit = 1'b1;
        end
        CONT_SET_PROBE: begin
          shadow_next.p2width = wr_data;
          wr_hit = 1'b1;
        end
        CONT_TOGGLE_PUMP: begin
          shadow_next.pump   = wr_data[0];
          shadow_next.double = wr_data[1];
          wr_hit = 1'b1;
        end
        CONT_SET_ATT: begin
          shadow_next.pp_probe = wr_data[6:0];
          shadow_next.post_att = wr_data[14:8];
          shadow_next.pp_pump  = wr_data[22:16];
          shadow_next.pp_on    = wr_data[24];
          wr_hit = 1'b1;
        end
        default: wr_hit = 1'b0;
      endcase
    end
  end

  // The commit reads the pre-write shadow, so a write landing in the strobe
  // cycle waits for the next period_end instead of mixing into this one.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= CFG_RESET;
      active      <= CFG_RESET;
      edges       <= EDGES_RESET;
      cfg_pending <= 1'b0;
    end else begin
      if (period_end && cfg_pending) begin
        active <= shadow;
      end
      shadow      <= shadow_next;
      edges       <= derive_edges(active);
      cfg_pending <= wr_hit | (cfg_pending & ~period_end);
    end
  end

endmodule

// File: rtl/pulse_param_sched.sv
// UART command front end: assembles 5-byte frames, feeds the parameter bank,
// enforces an inter-byte timeout and returns one reply byte per frame.
module pulse_param_sched
  import pulse_param_sched_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  input  logic        period_end,
  output logic [31:0] period,
  output logic [31:0] p1width,
  output logic [31:0] p2width,
  output logic [31:0] delay,
  output logic [31:0] p2start,
  output logic [31:0] sync_up,
  output logic [31:0] att_down,
  output logic        pump,
  output logic        double,
  output logic        pp_on,
  output logic [6:0]  pp_probe,
  output logic [6:0]  pp_pump,
  output logic [6:0]  post_att,
  output logic        cfg_pending,
  output logic        frame_err
);

  rx_state_e   rx_state, rx_next;
  tx_state_e   tx_state, tx_next;
  logic        rx_prev;
  logic        byte_stb;
  logic [1:0]  byte_cnt;
  logic [31:0] data_reg;
  logic [7:0]  ctrl_reg;
  logic [23:0] idle_cnt;
  logic        in_frame;
  logic        timeout;
  logic        exec;
  logic        code_ok;
  logic [7:0]  csum;
  logic        reply_pending;
  logic [7:0]  reply_byte;
  logic        tx_go;
  cfg_t        active;
  edges_t      edges;

  // A level-type 'received' flag may be held for several clocks; only its rising edge counts.
  assign byte_stb = rx_valid & ~rx_prev;
  assign in_frame = (rx_state == RX_DATA) || (rx_state == RX_CTRL);
  assign timeout  = in_frame && (idle_cnt == TIMEOUT_CYC);
  assign exec     = (rx_state == RX_EXEC);
  assign code_ok  = (ctrl_reg <= CONT_READ_TEST);
  assign csum     = data_reg[7:0] + data_reg[15:8] + data_reg[23:16] + data_reg[31:24];

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: if (byte_stb) rx_next = RX_DATA;
      RX_DATA: begin
        if (timeout)                         rx_next = RX_IDLE;
        else if (byte_stb && byte_cnt == 2'd3) rx_next = RX_CTRL;
      end
      RX_CTRL: begin
        if (timeout)       rx_next = RX_IDLE;
        else if (byte_stb) rx_next = RX_EXEC;
      end
      RX_EXEC: rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state  <= RX_IDLE;
      rx_prev   <= 1'b0;
      byte_cnt  <= 2'd0;
      data_reg  <= 32'd0;
      ctrl_reg  <= 8'd0;
      idle_cnt  <= 24'd0;
      frame_err <= 1'b0;
    end else begin
      rx_state <= rx_next;
      rx_prev  <= rx_valid;

      if (byte_stb || !in_frame) idle_cnt <= 24'd0;
      else                       idle_cnt <= idle_cnt + 24'd1;

      if (!timeout && byte_stb) begin
        case (rx_state)
          RX_IDLE: begin
            data_reg[7:0] <= rx_byte;
            byte_cnt      <= 2'd1;
          end
          RX_DATA: begin
            data_reg[{byte_cnt, 3'b000} +: 8] <= rx_byte;
            byte_cnt                          <= byte_cnt + 2'd1;
          end
          RX_CTRL: ctrl_reg <= rx_byte;
          default: ;
        endcase
      end

      if (timeout)                                frame_err <= 1'b1;
      else if (exec && !code_ok)                  frame_err <= 1'b1;
      else if (exec && ctrl_reg == CONT_READ_TEST) frame_err <= 1'b0;
    end
  end

  assign tx_go = (tx_state == TX_IDLE) && reply_pending && !tx_busy;

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:    if (tx_go)    tx_next = TX_WAIT_HI;
      TX_WAIT_HI: if (tx_busy)  tx_next = TX_WAIT_LO;
      TX_WAIT_LO: if (!tx_busy) tx_next = TX_IDLE;
      default:    tx_next = TX_IDLE;
    endcase
  end

  // tx_byte is latched at launch so a reply arriving mid-send only replaces the queued byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state      <= TX_IDLE;
      tx_start      <= 1'b0;
      tx_byte       <= 8'd0;
      reply_pending <= 1'b0;
      reply_byte    <= 8'd0;
    end else begin
      tx_state <= tx_next;
      tx_start <= tx_go;
      if (tx_go) tx_byte <= reply_byte;
      if (exec) begin
        reply_pending <= 1'b1;
        reply_byte    <= code_ok ? csum : ~csum;
      end else if (tx_go) begin
        reply_pending <= 1'b0;
      end
    end
  end

  pulse_param_sched_bank u_bank (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (exec),
    .wr_code     (ctrl_reg),
    .wr_data     (data_reg),
    .period_end  (period_end),
    .active      (active),
    .edges       (edges),
    .cfg_pending (cfg_pending)
  );

  assign period   = active.period;
  assign p1width  = active.p1width;
  assign p2width  = active.p2width;
  assign delay    = active.delay;
  assign pump     = active.pump;
  assign double   = active.double;
  assign pp_on    = active.pp_on;
  assign pp_probe = active.pp_probe;
  assign pp_pump  = active.pp_pump;
  assign post_att = active.post_att;
  assign p2start  = edges.p2start;
  assign sync_up  = edges.sync_up;
  assign att_down = edges.att_down;

endmodule
